// File: rtl/cipher_stream_engine_if.sv
// Character stream bundle between the source, the cipher engine and the display driver.
// The master drives input beats and output ready; the slave (engine) drives the rest.
interface cipher_stream_engine_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/cipher_stream_engine.sv
// Streaming Vigenere cipher for ASCII alphanumerics with a programmable key table.
// One output register gives full throughput; mode and key length lock per message.
module cipher_stream_engine #(
    parameter  int unsigned KEY_DEPTH = 8,
    localparam int unsigned KW        = $clog2(KEY_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          key_wr_en,
    input  logic [KW-1:0]                 key_wr_addr,
    input  logic [7:0]                    key_wr_data,
    input  logic [KW:0]                   key_len,
    input  logic                          mode,
    output logic                          busy,
    cipher_stream_engine_if.slave         strm
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    key_mem [KEY_DEPTH];
    logic [KW-1:0] idx;
    logic [KW-1:0] idx_nxt;
    logic          mode_q;
    logic          mode_nxt;
    logic [KW:0]   len_q;
    logic [KW:0]   len_nxt;
    logic          out_valid_nxt;
    logic [7:0]    out_data_nxt;
    logic          out_last_nxt;
    logic          busy_nxt;

    logic          in_fire;
    logic          key_we;
    logic [KW:0]   key_len_sat;
    logic          cur_mode;
    logic [KW:0]   cur_len;
    logic [7:0]    key_k;
    logic          is_digit;
    logic          is_upper;
    logic          is_lower;
    logic          is_alnum;
    logic          advance;
    logic [7:0]    range_lo;
    logic [7:0]    range_size;
    logic [7:0]    shift;
    logic [8:0]    range_hi;
    logic [8:0]    shifted;
    logic [7:0]    xform;

    assign strm.in_ready = !strm.out_valid || strm.out_ready;
    assign in_fire       = strm.in_valid && strm.in_ready;

    // Table writes only land between messages and never alongside an accepted beat
    assign key_we = rst_n && key_wr_en && (state == IDLE) && !in_fire;

    assign key_len_sat = (key_len > (KW+1)'(KEY_DEPTH)) ? (KW+1)'(KEY_DEPTH) : key_len;
    assign cur_mode    = (state == IDLE) ? mode : mode_q;
    assign cur_len     = (state == IDLE) ? key_len_sat : len_q;
    assign key_k       = key_mem[idx];

    assign is_digit = (strm.in_data >= 8'h30) && (strm.in_data <= 8'h39);
    assign is_upper = (strm.in_data >= 8'h41) && (strm.in_data <= 8'h5A);
    assign is_lower = (strm.in_data >= 8'h61) && (strm.in_data <= 8'h7A);
    assign is_alnum = is_digit || is_upper || is_lower;
    assign advance  = is_alnum && (cur_len != '0);

    // Character transform: shift within the character's own range, in 9 bits
    always_comb begin
        range_lo   = 8'h00;
        range_size = 8'd0;
        shift      = 8'd0;
        if (is_digit) begin
            range_lo   = 8'h30;
            range_size = 8'd10;
            shift      = key_k % 8'd10;
        end else if (is_upper) begin
            range_lo   = 8'h41;
            range_size = 8'd26;
            shift      = key_k % 8'd26;
        end else if (is_lower) begin
            range_lo   = 8'h61;
            range_size = 8'd26;
            shift      = key_k % 8'd26;
        end
        range_hi = {1'b0, range_lo} + {1'b0, range_size} - 9'd1;
        if (!cur_mode) begin
            shifted = {1'b0, strm.in_data} + {1'b0, shift};
            if (shifted > range_hi) begin
                shifted = shifted - {1'b0, range_size};
            end
        end else begin
            shifted = {1'b0, strm.in_data} - {1'b0, shift};
            if (shifted < {1'b0, range_lo}) begin
                shifted = shifted + {1'b0, range_size};
            end
        end
        xform = advance ? shifted[7:0] : strm.in_data;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        mode_nxt      = mode_q;
        len_nxt       = len_q;
        out_valid_nxt = strm.out_valid;
        out_data_nxt  = strm.out_data;
        out_last_nxt  = strm.out_last;

        if (strm.in_ready) begin
            out_valid_nxt = in_fire;
        end

        if (in_fire) begin
            out_data_nxt = xform;
            out_last_nxt = strm.in_last;
            if (state == IDLE) begin
                mode_nxt = mode;
                len_nxt  = key_len_sat;
            end
            if (advance) begin
                idx_nxt = ((KW+1)'(idx) == (cur_len - (KW+1)'(1))) ? '0 : idx + KW'(1);
            end
            case (state)
                IDLE:    if (!strm.in_last) state_nxt = RUN;
                RUN:     if (strm.in_last)  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
            if (strm.in_last) begin
                idx_nxt = '0;
            end
        end

        busy_nxt = (state_nxt == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            mode_q        <= 1'b0;
            len_q         <= '0;
            strm.out_valid <= 1'b0;
            strm.out_data  <= 8'h00;
            strm.out_last  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            mode_q        <= mode_nxt;
            len_q         <= len_nxt;
            strm.out_valid <= out_valid_nxt;
            strm.out_data  <= out_data_nxt;
            strm.out_last  <= out_last_nxt;
            busy          <= busy_nxt;
        end
    end

    // Key table survives reset
    always_ff @(posedge clk) begin
        if (key_we) begin
            key_mem[key_wr_addr] <= key_wr_data;
        end
    end

endmodule

// File: tb/tb_cipher_stream_engine.sv
// Randomized and directed bench for cipher_stream_engine against a message-level model.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_cipher_stream_engine;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned KW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          key_wr_en;
    logic [KW-1:0] key_wr_addr;
    logic [7:0]    key_wr_data;
    logic [KW:0]   key_len;
    logic          mode;
    logic          busy;

    cipher_stream_engine_if bus();

    cipher_stream_engine #(.KEY_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_wr_en   (key_wr_en),
        .key_wr_addr (key_wr_addr),
        .key_wr_data (key_wr_data),
        .key_len     (key_len),
        .mode        (mode),
        .busy        (busy),
        .strm        (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model state
    logic [7:0]  m_key [DEPTH];
    bit          m_busy;
    bit          m_mode;
    int          m_len;
    int          m_idx;
    logic [7:0]  exp_q [$];
    bit          exp_last_q [$];
    logic [7:0]  msg_q [$];

    logic [63:0] out_hist;
    bit          fired;
    bit          post_rst;
    bit          prev_in_fire;
    bit          prev_hold;
    logic [7:0]  held_data;
    logic        held_last;
    int          stall_left;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_cipher(input logic [7:0] c, input logic [7:0] k, input bit dec);
        int lo;
        int n;
        int s;
        int off;
        if (c >= "0" && c <= "9") begin lo = "0"; n = 10; end
        else if (c >= "A" && c <= "Z") begin lo = "A"; n = 26; end
        else if (c >= "a" && c <= "z") begin lo = "a"; n = 26; end
        else return c;
        s   = int'(k) % n;
        off = int'(c) - lo;
        off = dec ? (off - s + n) % n : (off + s) % n;
        return 8'(lo + off);
    endfunction

    function automatic bit is_alnum(input logic [7:0] c);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
    endfunction

    // One clock: check and update the model at the falling edge, then release to the next edge
    task automatic step();
        bit          in_fire;
        logic [7:0]  o;
        int          kl;
        @(negedge clk);
        fired = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_idx  = 0;
            exp_q.delete();
            exp_last_q.delete();
            post_rst     = 1'b1;
            prev_in_fire = 1'b0;
            prev_hold    = 1'b0;
        end else begin
            check("in_ready", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
            check("busy", 64'(busy), 64'(m_busy));
            if (post_rst) check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
            post_rst = 1'b0;
            if (prev_in_fire) check("latency_out_valid", 64'(bus.out_valid), 64'd1);
            if (prev_hold) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_data", 64'(bus.out_data), 64'(held_data));
                check("hold_last", 64'(bus.out_last), 64'(held_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_output", 64'(bus.out_data), 64'hFFFF);
                end else begin
                    check("out_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
                    check("out_last", 64'(bus.out_last), 64'(exp_last_q.pop_front()));
                end
                out_hist = {out_hist[55:0], bus.out_data};
            end
            in_fire = bus.in_valid && bus.in_ready;
            if (key_wr_en && !m_busy && !in_fire) m_key[key_wr_addr] = key_wr_data;
            if (in_fire) begin
                if (!m_busy) begin
                    kl     = int'(key_len);
                    m_mode = mode;
                    m_len  = (kl > int'(DEPTH)) ? int'(DEPTH) : kl;
                end
                o = bus.in_data;
                if (is_alnum(bus.in_data) && m_len > 0) begin
                    o     = ref_cipher(bus.in_data, m_key[m_idx], m_mode);
                    m_idx = (m_idx + 1) % m_len;
                end
                exp_q.push_back(o);
                exp_last_q.push_back(bus.in_last);
                if (bus.in_last) begin
                    m_idx  = 0;
                    m_busy = 1'b0;
                end else begin
                    m_busy = 1'b1;
                end
            end
            fired        = in_fire;
            prev_in_fire = in_fire;
            prev_hold    = bus.out_valid && !bus.out_ready;
            held_data    = bus.out_data;
            held_last    = bus.out_last;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        key_wr_en    = 1'b0;
        step();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
    endtask

    task automatic write_key(input int addr, input int data);
        key_wr_en   = 1'b1;
        key_wr_addr = KW'(addr);
        key_wr_data = 8'(data);
        step();
        key_wr_en   = 1'b0;
    endtask

    task automatic load(input string s);
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endtask

    task automatic send_msg(input bit md, input int klen, input bit bp,
                            input int stall_at, input int toggle_at, input bit end_last);
        bit acc;
        out_hist   = '0;
        stall_left = 0;
        mode       = md;
        key_len    = (KW+1)'(klen);
        for (int i = 0; i < msg_q.size(); i++) begin
            if (bp && $urandom_range(0, 3) == 0) begin
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'($urandom_range(0, 1));
                step();
            end
            bus.in_valid = 1'b1;
            bus.in_data  = msg_q[i];
            bus.in_last  = end_last && (i == msg_q.size() - 1);
            if (i == toggle_at) begin
                mode        = !md;
                key_len     = (KW+1)'(klen == 0 ? 1 : 0);
                key_wr_en   = 1'b1;
                key_wr_addr = '0;
                key_wr_data = 8'd7;
            end
            if (i == stall_at) stall_left = 5;
            acc = 1'b0;
            for (int t = 0; t < 200 && !acc; t++) begin
                if (stall_left > 0) begin
                    bus.out_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
                step();
                acc = fired;
            end
            if (!acc) check("accept_timeout", 64'd0, 64'd1);
            key_wr_en = 1'b0;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        for (int t = 0; t < 100 && (exp_q.size() > 0 || stall_left > 0); t++) begin
            if (stall_left > 0) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready = 1'b1;
            end
            step();
        end
        bus.out_ready = 1'b1;
        step();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic rand_msg(input int len);
        int r;
        msg_q.delete();
        for (int i = 0; i < len; i++) begin
            r = $urandom_range(0, 5);
            case (r)
                0: msg_q.push_back(8'($urandom_range(8'h30, 8'h39)));
                1: msg_q.push_back(8'($urandom_range(8'h41, 8'h5A)));
                2: msg_q.push_back(8'($urandom_range(8'h61, 8'h7A)));
                3: msg_q.push_back(8'($urandom_range(8'h20, 8'h2F)));
                4: msg_q.push_back(8'($urandom_range(8'h80, 8'hFF)));
                default: msg_q.push_back(8'($urandom_range(0, 255)));
            endcase
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        key_wr_en     = 1'b0;
        key_wr_addr   = '0;
        key_wr_data   = 8'h00;
        key_len       = '0;
        mode          = 1'b0;
        m_busy        = 1'b0;
        m_mode        = 1'b0;
        m_len         = 0;
        m_idx         = 0;
        out_hist      = '0;
        post_rst      = 1'b0;
        prev_in_fire  = 1'b0;
        prev_hold     = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) m_key[i] = 8'h00;

        do_reset();
        step();
        for (int i = 0; i < int'(DEPTH); i++) write_key(i, 0);

        // Single key encrypt and decrypt
        write_key(0, 3);
        load("Az9!"); send_msg(1'b0, 1, 1'b0, -1, -1, 1'b1); drain();
        check("enc_Az9", out_hist, 64'h0000_0000_4463_3221);
        load("Dc2!"); send_msg(1'b1, 1, 1'b0, -1, -1, 1'b1); drain();
        check("dec_Dc2", out_hist, 64'h0000_0000_417A_3921);

        // Vigenere with punctuation skip and high-end wrap
        write_key(0, 1); write_key(1, 2);
        load("ab c"); send_msg(1'b0, 2, 1'b0, -1, -1, 1'b1); drain();
        check("vig_ab_c", out_hist, 64'h0000_0000_6264_2064);
        write_key(0, 25); write_key(1, 25);
        load("zZ9"); send_msg(1'b0, 2, 1'b0, -1, -1, 1'b1); drain();
        check("wrap_zZ9", out_hist, 64'h0000_0000_0079_5934);

        // Backpressure mid-stream
        load("Hello World 123"); send_msg(1'b0, 2, 1'b0, 4, -1, 1'b1); drain();

        // Mode, length and key locked while busy
        write_key(0, 4);
        load("abcd"); send_msg(1'b0, 1, 1'b0, -1, 2, 1'b1); drain();
        check("lock_abcd", out_hist, 64'h0000_0000_6566_6768);
        load("a"); send_msg(1'b0, 1, 1'b0, -1, -1, 1'b1); drain();
        check("key_retained", out_hist, 64'h0000_0000_0000_0065);

        // Edge lengths and single-beat message
        write_key(0, 5);
        load("A"); send_msg(1'b0, 1, 1'b0, -1, -1, 1'b1); drain();
        check("single_A", out_hist, 64'h0000_0000_0000_0046);
        check("single_busy", 64'(busy), 64'd0);
        load("Hi5"); send_msg(1'b0, 0, 1'b0, -1, -1, 1'b1); drain();
        check("len0_pass", out_hist, 64'h0000_0000_0048_6935);
        for (int i = 0; i < int'(DEPTH); i++) write_key(i, i + 1);
        load("aaaaaaaaa"); send_msg(1'b0, 15, 1'b0, -1, -1, 1'b1); drain();
        check("len15_wrap", out_hist, 64'h6364_6566_6768_6962);

        // Reset mid-message, key table retained
        write_key(0, 3);
        load("abc"); send_msg(1'b0, 2, 1'b0, -1, -1, 1'b0);
        rst_n = 1'b0;
        step();
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        rst_n = 1'b1;
        step();
        load("a!"); send_msg(1'b0, 1, 1'b0, -1, -1, 1'b1); drain();
        check("midrst_restart", out_hist, 64'h0000_0000_0000_6421);

        // Randomized messages with random keys and backpressure
        for (int m = 0; m < 40; m++) begin
            for (int w = 0; w < int'($urandom_range(0, 3)); w++)
                write_key(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)));
            rand_msg(int'($urandom_range(1, 14)));
            send_msg(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 1'b1,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : -1, 1'b1);
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
